// File: rtl/dsp_op_scheduler.sv
// dsp_op_scheduler: round-robin two-requester issuer for the fracturable DSP, with ordered result tagging.
// Optional MAC grant lock enabled by defining DSP_SCHED_MAC_LOCK_EN.
`default_nettype none

module dsp_op_scheduler #(
  parameter int WIDTH      = 33,
  parameter int SHIFT_BITS = 2,
  parameter int RES_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [1:0]            req0_mode,
  input  logic                  req0_mac,
  input  logic [SHIFT_BITS-1:0] req0_shift_amount,
  input  logic                  req0_shift_dir,
  input  logic [WIDTH-1:0]      req0_aa,
  input  logic [WIDTH-1:0]      req0_bb,
  input  logic [2*WIDTH-1:0]    req0_cc,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [1:0]            req1_mode,
  input  logic                  req1_mac,
  input  logic [SHIFT_BITS-1:0] req1_shift_amount,
  input  logic                  req1_shift_dir,
  input  logic [WIDTH-1:0]      req1_aa,
  input  logic [WIDTH-1:0]      req1_bb,
  input  logic [2*WIDTH-1:0]    req1_cc,
  output logic                  dsp_start,
  output logic [1:0]            dsp_mode,
  output logic                  dsp_mac,
  output logic [SHIFT_BITS-1:0] dsp_shift_amount,
  output logic                  dsp_shift_dir,
  output logic [WIDTH-1:0]      dsp_aa,
  output logic [WIDTH-1:0]      dsp_bb,
  output logic [2*WIDTH-1:0]    dsp_cc,
  input  logic [2*WIDTH-1:0]    dsp_out,
  output logic                  res_valid,
  output logic                  res_id,
  output logic [2*WIDTH-1:0]    res_data,
  output logic                  busy
);

  // Deepest tag slot is OCC(full)+RES_LAT-1.
  localparam int PIPE_D = 4 + RES_LAT;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                r_state;
  logic [2:0]            r_occ_cnt;
  logic                  r_prio;
  logic                  r_start;
  logic [1:0]            r_mode;
  logic                  r_mac;
  logic [SHIFT_BITS-1:0] r_shamt;
  logic                  r_shdir;
  logic [WIDTH-1:0]      r_aa;
  logic [WIDTH-1:0]      r_bb;
  logic [2*WIDTH-1:0]    r_cc;
  logic [PIPE_D-1:0]     r_tv;
  logic [PIPE_D-1:0]     r_tid;
  logic                  r_res_valid;
  logic                  r_res_id;
  logic [2*WIDTH-1:0]    r_res_data;
`ifdef DSP_SCHED_MAC_LOCK_EN
  logic                  r_lock;
  logic                  r_lock_id;
`endif

  logic                  w_can;
  logic                  w_rr0;
  logic                  w_rr1;
  logic                  w_rdy0;
  logic                  w_rdy1;
  logic                  w_acc;
  logic                  w_sel;
  logic [1:0]            w_mode;
  logic [1:0]            w_mode_n;
  logic                  w_mac;
  logic [2:0]            w_occ;
  int                    w_tidx;
  logic [PIPE_D-1:0]     w_tv_sh;
  logic [PIPE_D-1:0]     w_tid_sh;

  assign w_can = (r_occ_cnt <= 3'd1);
  assign w_rr0 = r_prio ? (req0_valid && !req1_valid) : req0_valid;
  assign w_rr1 = r_prio ? req1_valid : (req1_valid && !req0_valid);

  // Ready is forced low while reset is held so every output reads 0.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!rst && w_can) begin
`ifdef DSP_SCHED_MAC_LOCK_EN
      if (r_lock) begin
        w_rdy0 = req0_valid && !r_lock_id;
        w_rdy1 = req1_valid && r_lock_id;
      end else begin
        w_rdy0 = w_rr0;
        w_rdy1 = w_rr1;
      end
`else
      w_rdy0 = w_rr0;
      w_rdy1 = w_rr1;
`endif
    end
  end

  assign w_acc    = w_rdy0 || w_rdy1;
  assign w_sel    = w_rdy1;
  assign w_mode   = w_sel ? req1_mode : req0_mode;
  assign w_mode_n = (w_mode == 2'd3) ? 2'd2 : w_mode;
  assign w_mac    = w_sel ? req1_mac : req0_mac;

  always_comb begin
    case (w_mode_n)
      2'd0:    w_occ = 3'd1;
      2'd1:    w_occ = 3'd2;
      default: w_occ = 3'd4;
    endcase
  end

  // Slot chosen so the tag reaches slot 0 in the cycle dsp_out is valid.
  assign w_tidx   = int'(w_occ) + RES_LAT - 1;
  assign w_tv_sh  = {1'b0, r_tv[PIPE_D-1:1]};
  assign w_tid_sh = {1'b0, r_tid[PIPE_D-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_occ_cnt   <= 3'd0;
      r_prio      <= 1'b0;
      r_start     <= 1'b0;
      r_mode      <= 2'd0;
      r_mac       <= 1'b0;
      r_shamt     <= '0;
      r_shdir     <= 1'b0;
      r_aa        <= '0;
      r_bb        <= '0;
      r_cc        <= '0;
      r_tv        <= '0;
      r_tid       <= '0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_data  <= '0;
`ifdef DSP_SCHED_MAC_LOCK_EN
      r_lock      <= 1'b0;
      r_lock_id   <= 1'b0;
`endif
    end else begin
      r_start <= w_acc;
      if (w_acc) begin
        r_state   <= S_BUSY;
        r_occ_cnt <= w_occ;
        r_prio    <= ~w_sel;
        r_mode    <= w_mode_n;
        r_mac     <= w_mac;
        r_shamt   <= w_sel ? req1_shift_amount : req0_shift_amount;
        r_shdir   <= w_sel ? req1_shift_dir : req0_shift_dir;
        r_aa      <= w_sel ? req1_aa : req0_aa;
        r_bb      <= w_sel ? req1_bb : req0_bb;
        r_cc      <= w_sel ? req1_cc : req0_cc;
`ifdef DSP_SCHED_MAC_LOCK_EN
        if (w_mac) begin
          r_lock    <= 1'b1;
          r_lock_id <= w_sel;
        end else begin
          r_lock    <= 1'b0;
        end
`endif
      end else if (r_state == S_BUSY) begin
        r_occ_cnt <= r_occ_cnt - 3'd1;
        if (r_occ_cnt <= 3'd1) r_state <= S_IDLE;
      end

      for (int i = 0; i < PIPE_D; i++) begin
        if (w_acc && (i == w_tidx)) begin
          r_tv[i]  <= 1'b1;
          r_tid[i] <= w_sel;
        end else begin
          r_tv[i]  <= w_tv_sh[i];
          r_tid[i] <= w_tid_sh[i];
        end
      end

      r_res_valid <= r_tv[0];
      r_res_id    <= r_tid[0];
      if (r_tv[0]) r_res_data <= dsp_out;
    end
  end

  assign req0_ready       = w_rdy0;
  assign req1_ready       = w_rdy1;
  assign dsp_start        = r_start;
  assign dsp_mode         = r_mode;
  assign dsp_mac          = r_mac;
  assign dsp_shift_amount = r_shamt;
  assign dsp_shift_dir    = r_shdir;
  assign dsp_aa           = r_aa;
  assign dsp_bb           = r_bb;
  assign dsp_cc           = r_cc;
  assign res_valid        = r_res_valid;
  assign res_id           = r_res_id;
  assign res_data         = r_res_data;
  assign busy             = (r_state == S_BUSY) || (|r_tv);

endmodule

`default_nettype wire

// File: tb/tb_dsp_op_scheduler.sv
// tb_dsp_op_scheduler: directed bench with a fixed-latency DSP stub (RES_LAT=2).
`default_nettype none

module tb_dsp_op_scheduler;

  localparam int W  = 33;
  localparam int SB = 2;
  localparam int RL = 2;

  localparam int SC_PLAIN  = 0;
  localparam int SC_STREAM = 1;
  localparam int SC_MACS   = 2;
  localparam int SC_B2B    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready, req0_mac, req0_shift_dir;
  logic [1:0]      req0_mode;
  logic [SB-1:0]   req0_shift_amount;
  logic [W-1:0]    req0_aa, req0_bb;
  logic [2*W-1:0]  req0_cc;
  logic            req1_valid, req1_ready, req1_mac, req1_shift_dir;
  logic [1:0]      req1_mode;
  logic [SB-1:0]   req1_shift_amount;
  logic [W-1:0]    req1_aa, req1_bb;
  logic [2*W-1:0]  req1_cc;
  logic            dsp_start, dsp_mac, dsp_shift_dir;
  logic [1:0]      dsp_mode;
  logic [SB-1:0]   dsp_shift_amount;
  logic [W-1:0]    dsp_aa, dsp_bb;
  logic [2*W-1:0]  dsp_cc, dsp_out;
  logic            res_valid, res_id, busy;
  logic [2*W-1:0]  res_data;

  dsp_op_scheduler #(.WIDTH(W), .SHIFT_BITS(SB), .RES_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode), .req0_mac(req0_mac),
    .req0_shift_amount(req0_shift_amount), .req0_shift_dir(req0_shift_dir),
    .req0_aa(req0_aa), .req0_bb(req0_bb), .req0_cc(req0_cc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode), .req1_mac(req1_mac),
    .req1_shift_amount(req1_shift_amount), .req1_shift_dir(req1_shift_dir),
    .req1_aa(req1_aa), .req1_bb(req1_bb), .req1_cc(req1_cc),
    .dsp_start(dsp_start), .dsp_mode(dsp_mode), .dsp_mac(dsp_mac),
    .dsp_shift_amount(dsp_shift_amount), .dsp_shift_dir(dsp_shift_dir),
    .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc), .dsp_out(dsp_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DSP stub: result aa*bb+cc valid OCC+RL-1 cycles after the start cycle.
  logic [2*W-1:0] stub_d [0:15];
  int             stub_k;
  assign stub_k  = ((dsp_mode == 2'd0) ? 1 : (dsp_mode == 2'd1) ? 2 : 4) + RL - 2;
  assign dsp_out = stub_d[0];
  initial for (int i = 0; i < 16; i++) stub_d[i] = '0;
  always @(posedge clk) begin
    for (int i = 0; i < 15; i++) stub_d[i] <= stub_d[i+1];
    stub_d[15] <= '0;
    if (dsp_start) stub_d[stub_k] <= (2*W)'(dsp_aa) * (2*W)'(dsp_bb) + dsp_cc;
  end

  int             n_cmp = 0;
  int             n_err = 0;
  int             n_acc0 = 0;
  int             n_acc1 = 0;
  int             scen = SC_PLAIN;
  int             a_cyc[$];
  bit             a_id[$];
  int             s_cyc[$];
  bit [1:0]       s_mode[$];
  bit             s_mac[$];
  int             q_cyc[$];
  bit             q_id[$];
  logic [2*W-1:0] q_dat[$];

  task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample();
    if (req0_valid && req0_ready) begin a_cyc.push_back(cyc); a_id.push_back(1'b0); n_acc0++; end
    if (req1_valid && req1_ready) begin a_cyc.push_back(cyc); a_id.push_back(1'b1); n_acc1++; end
    if (dsp_start) begin s_cyc.push_back(cyc); s_mode.push_back(dsp_mode); s_mac.push_back(dsp_mac); end
    if (res_valid) begin q_cyc.push_back(cyc); q_id.push_back(res_id); q_dat.push_back(res_data); end
  endtask

  // Inputs change 1ns after posedge; outputs are sampled on negedge.
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    a_cyc.delete(); a_id.delete(); s_cyc.delete(); s_mode.delete(); s_mac.delete();
    q_cyc.delete(); q_id.delete(); q_dat.delete();
  endtask

  task automatic run(input int n0, input int n1, input int cycles);
    int b0, b1;
    b0 = n_acc0;
    b1 = n_acc1;
    for (int c = 0; c < cycles; c++) begin
      req0_valid = (n_acc0 - b0) < n0;
      req1_valid = ((n_acc1 - b1) < n1) && (scen != SC_STREAM || n_acc0 > b0);
      if (scen == SC_MACS) req0_mac = (n_acc0 - b0) < 2;
      if (scen == SC_B2B)  req1_aa  = W'(n_acc1 - b1 + 1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int e_gap[5] = '{4, 1, 4, 1, 4};
`ifdef DSP_SCHED_MAC_LOCK_EN
  int e_mid[4]  = '{0, 0, 0, 1};
  int e_mmac[4] = '{1, 1, 0, 0};
`else
  int e_mid[4]  = '{0, 1, 0, 0};
  int e_mmac[4] = '{1, 0, 1, 0};
`endif

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_mode = 2'd0; req0_mac = 1'b0; req0_shift_amount = '0; req0_shift_dir = 1'b0;
    req0_aa = '0; req0_bb = '0; req0_cc = '0;
    req1_valid = 1'b1; req1_mode = 2'd0; req1_mac = 1'b0; req1_shift_amount = '0; req1_shift_dir = 1'b0;
    req1_aa = '0; req1_bb = '0; req1_cc = '0;
    repeat (3) tick();
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_start_busy", {dsp_start, busy, res_valid, res_id}, 0);
    chk("rst_dsp", dsp_aa | dsp_bb | dsp_cc | res_data | dsp_mode, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    repeat (2) tick();

    // Single mode-0 op from req0: 3*5
    clear_q();
    req0_aa = 3; req0_bb = 5; req0_cc = 0; req0_mode = 2'd0;
    run(1, 0, 1);
    chk("single_start_now", dsp_start, 1);
    chk("single_busy", busy, 1);
    run(0, 0, 10);
    chk("single_idle", busy, 0);
    chk("single_n_res", q_cyc.size(), 1);
    chk("single_start_lat", s_cyc[0] - a_cyc[0], 1);
    chk("single_res_lat", q_cyc[0] - a_cyc[0], 4);
    chk("single_res_data", q_dat[0], 15);
    chk("single_res_id", q_id[0], 0);
    chk("single_held_aa", dsp_aa, 3);

    // req0 mode 2 (2*3+1), req1 mode 0 (4*5), both streaming
    clear_q();
    scen = SC_STREAM;
    req0_mode = 2'd2; req0_aa = 2; req0_bb = 3; req0_cc = 1;
    req1_mode = 2'd0; req1_aa = 4; req1_bb = 5; req1_cc = 0;
    run(3, 3, 40);
    scen = SC_PLAIN;
    chk("stream_n_acc", a_cyc.size(), 6);
    chk("stream_n_res", q_cyc.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("stream_id%0d", i), a_id[i], i % 2);
      chk($sformatf("stream_res_id%0d", i), q_id[i], i % 2);
      chk($sformatf("stream_res_dat%0d", i), q_dat[i], (i % 2) ? 20 : 7);
      chk($sformatf("stream_res_lat%0d", i), q_cyc[i] - a_cyc[i], (i % 2) ? 4 : 7);
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("stream_start_gap%0d", i), s_cyc[i+1] - s_cyc[i], e_gap[i]);

    // Mode 3 issues as full precision
    clear_q();
    req1_mode = 2'd3; req1_aa = 6; req1_bb = 7; req1_cc = 0;
    run(0, 2, 20);
    chk("m3_mode0", s_mode[0], 2);
    chk("m3_mode1", s_mode[1], 2);
    chk("m3_gap", a_cyc[1] - a_cyc[0], 4);
    chk("m3_res_dat", q_dat[0], 42);
    chk("m3_res_lat", q_cyc[0] - a_cyc[0], 7);

    // req0 mac=1,1,0 while req1 is continuously valid
    clear_q();
    scen = SC_MACS;
    req0_mode = 2'd0; req0_aa = 1; req0_bb = 1; req0_cc = 0;
    req1_mode = 2'd0; req1_aa = 1; req1_bb = 1; req1_cc = 0; req1_mac = 1'b0;
    run(3, 1, 20);
    scen = SC_PLAIN;
    req0_mac = 1'b0;
    chk("mac_n_acc", a_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mac_id%0d", i), a_id[i], e_mid[i]);
      chk($sformatf("mac_fwd%0d", i), s_mac[i], e_mmac[i]);
    end

    // Reset one cycle after a mode 1 accept (9*9 must never return)
    clear_q();
    req0_mode = 2'd1; req0_aa = 9; req0_bb = 9; req0_cc = 0;
    run(1, 0, 1);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    tick();
    chk("midrst_ready", {req0_ready, req1_ready}, 0);
    chk("midrst_out", {dsp_start, busy, res_valid, res_id, dsp_mode}, 0);
    chk("midrst_dsp", dsp_aa | dsp_bb | res_data, 0);
    repeat (2) tick();
    rst = 1'b0;
    req0_mode = 2'd0; req0_aa = 1; req0_bb = 1;
    req1_mode = 2'd0; req1_aa = 2; req1_bb = 1; req1_cc = 0;
    run(1, 1, 15);
    chk("midrst_n_acc", a_cyc.size(), 3);
    chk("midrst_first_win", a_id[1], 0);
    chk("midrst_second", a_id[2], 1);
    chk("midrst_n_res", q_cyc.size(), 2);
    chk("midrst_res0", q_dat[0], 1);
    chk("midrst_res1", q_dat[1], 2);

    // Back-to-back mode 0 from req1: aa=i, bb=2
    clear_q();
    scen = SC_B2B;
    req1_mode = 2'd0; req1_bb = 2; req1_cc = 0;
    run(0, 8, 25);
    scen = SC_PLAIN;
    chk("b2b_n_start", s_cyc.size(), 8);
    chk("b2b_n_res", q_cyc.size(), 8);
    chk("b2b_res_lat", q_cyc[0] - a_cyc[0], 4);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_start_cyc%0d", i), s_cyc[i] - s_cyc[0], i);
      chk($sformatf("b2b_res_cyc%0d", i), q_cyc[i] - q_cyc[0], i);
      chk($sformatf("b2b_res_dat%0d", i), q_dat[i], 2 * (i + 1));
      chk($sformatf("b2b_res_id%0d", i), q_id[i], 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
